tilelink_uncached_sram_adapter: RTL and testbench
=================================================

# tilelink_uncached_sram_adapter

Uncached TileLink manager that terminates the single-client acquire/grant channel leaving the uncached TileLink arbiter and drives a single-port synchronous SRAM. It executes Get, GetBlock, Put and PutBlock as 64-bit beats, eight beats per block. It returns one grant per Get/Put and one grant per beat for GetBlock. Only one transaction is in flight at a time; acquire is back-pressured until the transaction's last grant fires.

## Interface
- SRAM_ADDR_BITS, 12, SRAM word-index width (64-bit words); index = {addr_block, beat}[SRAM_ADDR_BITS-1:0]
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- io_acquire_ready  out  1  adapter accepts acquire beat
- io_acquire_valid  in  1  acquire beat valid
- io_acquire_bits_addr_block  in  26  block address
- io_acquire_bits_client_xact_id  in  2  client transaction id
- io_acquire_bits_addr_beat  in  3  beat within block
- io_acquire_bits_is_builtin_type  in  1  built-in type flag
- io_acquire_bits_a_type  in  3  acquire type
- io_acquire_bits_union  in  12  union; [8:1] = byte write mask for Put/PutBlock
- io_acquire_bits_data  in  64  write data
- io_grant_ready  in  1  client accepts grant
- io_grant_valid  out  1  grant beat valid
- io_grant_bits_addr_beat  out  3  beat of this grant
- io_grant_bits_client_xact_id  out  2  echoed client id
- io_grant_bits_manager_xact_id  out  1  constant 0
- io_grant_bits_is_builtin_type  out  1  constant 1
- io_grant_bits_g_type  out  4  grant type
- io_grant_bits_data  out  64  read data (0 for acks)
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  write enable (valid with sram_en)
- sram_addr  out  SRAM_ADDR_BITS  word index
- sram_wdata  out  64  write data
- sram_wmask  out  8  byte write mask
- sram_rdata  in  64  read data, valid the cycle after a read strobe

## Operation
- Acquire types: Get=0, GetBlock=1, Put=2, PutBlock=3; others are unsupported. A beat with is_builtin_type=0 is also unsupported.
- Grant types: putAck=1, getDataBeat=3, getDataBlock=4.
- States: IDLE, RD, RWAIT, GNT, WR, WBEAT, ACK.
- IDLE: acquire_ready=1. On handshake, register the following: xact_id, addr_block, type, data and mask.
  - Beat counter = addr_beat for Get/Put, 0 for GetBlock/PutBlock.
  - Next state: RD for Get/GetBlock; WR for Put/PutBlock; ACK for unsupported.
- RD: sram_en=1, sram_we=0, addr from the registered block and beat. Next state RWAIT.
- RWAIT: capture sram_rdata into the grant data register. Next state GNT.
- GNT: grant_valid=1 with g_type 3 (Get) or 4 (GetBlock) and addr_beat = counter.
  - On grant handshake: for GetBlock with counter≠7, increment the counter and go to RD.
  - Otherwise go to IDLE.
- WR: sram_en=1, sram_we=1, registered wdata and wmask.
  - Put, or PutBlock with counter=7: next state ACK.
  - Otherwise increment the counter and go to WBEAT.
- WBEAT: acquire_ready=1; accept the next PutBlock beat, register its data and mask, go to WR.
  - Incoming addr_beat and a_type are ignored.
- ACK: grant_valid=1, g_type=1, addr_beat=0, data=0. On handshake go to IDLE. Unsupported types get no SRAM access.
- sram_en is 0 in every state except RD and WR.
- SRAM wraps modulo 2^SRAM_ADDR_BITS words. Upper address bits are discarded without error.

## Timing
- Reset: state IDLE, counter 0, all data and id registers 0. io_acquire_ready reads 1 (IDLE); every other output is 0 except manager_xact_id=0 and is_builtin_type=1. Upstream must hold valid low during reset.
- Get: acquire handshake cycle 0 → SRAM read cycle 1 → grant_valid from cycle 3 until grant_ready.
- GetBlock: first grant at cycle 3. Each later beat's grant is 3 cycles after the previous grant handshake. Beat order is 0..7.
- Put: handshake cycle 0 → SRAM write cycle 1 → ack valid cycle 2.
- PutBlock: beat k is written the cycle after it is accepted. acquire_ready reasserts the cycle after each write. The ack is valid the cycle after the beat-7 write.
- grant_valid and grant bits are stable while grant_ready=0; grant_valid never drops without a handshake.
- Grant and acquire are never both accepting in the same cycle, so there is no simultaneous-event hazard.
- reset_n low mid-transaction returns the block to IDLE immediately. The partial transaction is dropped and no grant is issued.

## Structure
- Shared package tl_uncached_pkg: a_type and g_type constants, state enum, beat width (3), data width (64).
- Single module, no sub-module. The beat counter and FSM are local.

## Test plan
- Put addr_block=0x5, beat=2, mask=0xFF, data=0xDEADBEEF_01234567, then Get same address → putAck (g_type 1) at cycle 2; Get grant g_type 3, beat 2, data 0xDEADBEEF_01234567 at cycle 3; client id echoed.
- PutBlock block 0x10, beats data=k*0x1111, then GetBlock → eight writes to indices 0x80..0x87; one ack; eight grants g_type 4, beats 0..7 with matching data.
- Partial mask: Put mask=0x0F, data=0xFFFFFFFF_FFFFFFFF over word 0 → Get returns 0x00000000_FFFFFFFF.
- Grant back-pressure: hold grant_ready=0 for 10 cycles during a GetBlock beat 4 → grant valid and bits stable; acquire_ready=0 throughout; beat 5 follows correctly.
- a_type=4, or is_builtin_type=0 → no sram_en pulse; single grant g_type 1, data 0; return to IDLE.
- Assert reset_n low during PutBlock beat 3 → sram_en=0 immediately; no grant; acquire_ready=1 after release; next Get completes normally.

Source files
------------

// File: rtl/tl_uncached_pkg.sv
// tl_uncached_pkg: shared TileLink uncached constants and adapter state encoding
package tl_uncached_pkg;
  localparam int BEAT_W = 3;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int BLOCK_W = 26;
  localparam logic [2:0] A_GET = 3'd0;
  localparam logic [2:0] A_GETBLOCK = 3'd1;
  localparam logic [2:0] A_PUT = 3'd2;
  localparam logic [2:0] A_PUTBLOCK = 3'd3;
  localparam logic [3:0] G_PUTACK = 4'd1;
  localparam logic [3:0] G_GETBEAT = 4'd3;
  localparam logic [3:0] G_GETBLOCK = 4'd4;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_GNT, S_WR, S_WBEAT, S_ACK} state_e;
endpackage

// File: rtl/tilelink_uncached_sram_adapter.sv
// tilelink_uncached_sram_adapter: single-transaction TileLink uncached manager over a 1-port SRAM
module tilelink_uncached_sram_adapter
  import tl_uncached_pkg::*;
#(
  parameter int SRAM_ADDR_BITS = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      io_acquire_ready,
  input  logic                      io_acquire_valid,
  input  logic [BLOCK_W-1:0]        io_acquire_bits_addr_block,
  input  logic [1:0]                io_acquire_bits_client_xact_id,
  input  logic [BEAT_W-1:0]         io_acquire_bits_addr_beat,
  input  logic                      io_acquire_bits_is_builtin_type,
  input  logic [2:0]                io_acquire_bits_a_type,
  input  logic [11:0]               io_acquire_bits_union,
  input  logic [DATA_W-1:0]         io_acquire_bits_data,
  input  logic                      io_grant_ready,
  output logic                      io_grant_valid,
  output logic [BEAT_W-1:0]         io_grant_bits_addr_beat,
  output logic [1:0]                io_grant_bits_client_xact_id,
  output logic                      io_grant_bits_manager_xact_id,
  output logic                      io_grant_bits_is_builtin_type,
  output logic [3:0]                io_grant_bits_g_type,
  output logic [DATA_W-1:0]         io_grant_bits_data,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [SRAM_ADDR_BITS-1:0] sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  output logic [MASK_W-1:0]         sram_wmask,
  input  logic [DATA_W-1:0]         sram_rdata
);
  state_e state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [1:0] xid_q, xid_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [2:0] typ_q, typ_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [BLOCK_W+BEAT_W-1:0] idx;
  logic unsupported;
  logic unused_bits;
  assign idx = {blk_q, cnt_q};
  assign unsupported = !io_acquire_bits_is_builtin_type || io_acquire_bits_a_type[2];
  assign unused_bits = ^{io_acquire_bits_union[11:9], io_acquire_bits_union[0], idx[BLOCK_W+BEAT_W-1:SRAM_ADDR_BITS]};
  assign io_acquire_ready = (state_q == S_IDLE) || (state_q == S_WBEAT);
  assign io_grant_valid = (state_q == S_GNT) || (state_q == S_ACK);
  assign io_grant_bits_g_type = (state_q == S_GNT) ? ((typ_q == A_GETBLOCK) ? G_GETBLOCK : G_GETBEAT)
                              : (state_q == S_ACK) ? G_PUTACK : 4'd0;
  assign io_grant_bits_addr_beat = (state_q == S_GNT) ? cnt_q : '0;
  assign io_grant_bits_data = (state_q == S_GNT) ? rdata_q : '0;
  assign io_grant_bits_client_xact_id = xid_q;
  assign io_grant_bits_manager_xact_id = 1'b0;
  assign io_grant_bits_is_builtin_type = 1'b1;
  assign sram_en = (state_q == S_RD) || (state_q == S_WR);
  assign sram_we = (state_q == S_WR);
  assign sram_addr = idx[SRAM_ADDR_BITS-1:0];
  assign sram_wdata = wdata_q;
  assign sram_wmask = wmask_q;
  // Next-state and register-update logic for the transaction sequencer
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    xid_d = xid_q;
    blk_d = blk_q;
    typ_d = typ_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (io_acquire_valid) begin
        xid_d = io_acquire_bits_client_xact_id;
        blk_d = io_acquire_bits_addr_block;
        typ_d = io_acquire_bits_a_type;
        wdata_d = io_acquire_bits_data;
        wmask_d = io_acquire_bits_union[8:1];
        cnt_d = io_acquire_bits_a_type[0] ? '0 : io_acquire_bits_addr_beat;
        state_d = unsupported ? S_ACK : io_acquire_bits_a_type[1] ? S_WR : S_RD;
      end
      S_RD: state_d = S_RWAIT;
      S_RWAIT: begin
        rdata_d = sram_rdata;
        state_d = S_GNT;
      end
      S_GNT: if (io_grant_ready) begin
        state_d = (typ_q == A_GETBLOCK && cnt_q != 3'd7) ? S_RD : S_IDLE;
        cnt_d = (typ_q == A_GETBLOCK && cnt_q != 3'd7) ? cnt_q + 3'd1 : cnt_q;
      end
      S_WR: begin
        state_d = (typ_q == A_PUT || cnt_q == 3'd7) ? S_ACK : S_WBEAT;
        cnt_d = (typ_q == A_PUT || cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
      end
      S_WBEAT: if (io_acquire_valid) begin
        wdata_d = io_acquire_bits_data;
        wmask_d = io_acquire_bits_union[8:1];
        state_d = S_WR;
      end
      S_ACK: state_d = io_grant_ready ? S_IDLE : S_ACK;
      default: state_d = S_IDLE;
    endcase
  end
  // State and datapath registers; reset drops any partial transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      xid_q <= '0;
      blk_q <= '0;
      typ_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      xid_q <= xid_d;
      blk_q <= blk_d;
      typ_q <= typ_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_tilelink_uncached_sram_adapter.sv
// tb_tilelink_uncached_sram_adapter: directed table, corner sequences and random traffic vs a word-array model
module tb_tilelink_uncached_sram_adapter;
  logic clk, reset_n;
  logic io_acquire_ready, io_acquire_valid;
  logic [25:0] io_acquire_bits_addr_block;
  logic [1:0] io_acquire_bits_client_xact_id;
  logic [2:0] io_acquire_bits_addr_beat;
  logic io_acquire_bits_is_builtin_type;
  logic [2:0] io_acquire_bits_a_type;
  logic [11:0] io_acquire_bits_union;
  logic [63:0] io_acquire_bits_data;
  logic io_grant_ready, io_grant_valid;
  logic [2:0] io_grant_bits_addr_beat;
  logic [1:0] io_grant_bits_client_xact_id;
  logic io_grant_bits_manager_xact_id, io_grant_bits_is_builtin_type;
  logic [3:0] io_grant_bits_g_type;
  logic [63:0] io_grant_bits_data;
  logic sram_en, sram_we;
  logic [11:0] sram_addr;
  logic [63:0] sram_wdata, sram_rdata;
  logic [7:0] sram_wmask;

  tilelink_uncached_sram_adapter #(.SRAM_ADDR_BITS(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .io_acquire_ready(io_acquire_ready), .io_acquire_valid(io_acquire_valid),
    .io_acquire_bits_addr_block(io_acquire_bits_addr_block),
    .io_acquire_bits_client_xact_id(io_acquire_bits_client_xact_id),
    .io_acquire_bits_addr_beat(io_acquire_bits_addr_beat),
    .io_acquire_bits_is_builtin_type(io_acquire_bits_is_builtin_type),
    .io_acquire_bits_a_type(io_acquire_bits_a_type),
    .io_acquire_bits_union(io_acquire_bits_union),
    .io_acquire_bits_data(io_acquire_bits_data),
    .io_grant_ready(io_grant_ready), .io_grant_valid(io_grant_valid),
    .io_grant_bits_addr_beat(io_grant_bits_addr_beat),
    .io_grant_bits_client_xact_id(io_grant_bits_client_xact_id),
    .io_grant_bits_manager_xact_id(io_grant_bits_manager_xact_id),
    .io_grant_bits_is_builtin_type(io_grant_bits_is_builtin_type),
    .io_grant_bits_g_type(io_grant_bits_g_type),
    .io_grant_bits_data(io_grant_bits_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with byte-masked writes and one-cycle read latency, plus activity monitor
  logic [63:0] mem [int];
  int en_cnt = 0;
  int gnt_cnt = 0;
  int wr_log [$];
  always @(posedge clk) begin
    logic [63:0] w;
    if (sram_en) begin
      en_cnt++;
      w = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 64'd0;
      if (sram_we) begin
        for (int b = 0; b < 8; b++) if (sram_wmask[b]) w[b*8+:8] = sram_wdata[b*8+:8];
        mem[int'(sram_addr)] = w;
        wr_log.push_back(int'(sram_addr));
      end else sram_rdata <= w;
    end
    if (io_grant_valid && io_grant_ready) gnt_cnt++;
  end

  logic [63:0] ref_mem [4096];
  int errors = 0;
  int checks = 0;

  function automatic int widx(input logic [25:0] blk, input logic [2:0] beat);
    return (int'(blk) * 8 + int'(beat)) % 4096;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8+:8] = d[b*8+:8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic acq(input logic [2:0] t, input logic bi, input logic [25:0] blk, input logic [2:0] beat,
                     input logic [7:0] mask, input logic [63:0] d, input logic [1:0] xid);
    int n = 0;
    @(negedge clk);
    io_acquire_valid = 1'b1;
    io_acquire_bits_a_type = t;
    io_acquire_bits_is_builtin_type = bi;
    io_acquire_bits_addr_block = blk;
    io_acquire_bits_addr_beat = beat;
    io_acquire_bits_union = {3'b0, mask, 1'b0};
    io_acquire_bits_data = d;
    io_acquire_bits_client_xact_id = xid;
    while (!io_acquire_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("acquire_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 io_acquire_valid = 1'b0;
  endtask

  task automatic grant(input string nm, input logic [3:0] eg, input logic [2:0] eb, input logic [63:0] ed,
                       input logic [1:0] ex, input int ecyc, input int hold);
    int cyc = 1;
    logic [63:0] sd;
    logic [8:0] sb;
    io_grant_ready = (hold == 0);
    @(negedge clk);
    while (!io_grant_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!io_grant_valid) begin
      chk({nm, "_timeout"}, 64'(cyc), 64'(ecyc));
      io_grant_ready = 1'b1;
      return;
    end
    if (ecyc > 0) chk({nm, "_latency"}, 64'(cyc), 64'(ecyc));
    chk({nm, "_gtype"}, 64'(io_grant_bits_g_type), 64'(eg));
    chk({nm, "_beat"}, 64'(io_grant_bits_addr_beat), 64'(eb));
    chk({nm, "_data"}, io_grant_bits_data, ed);
    chk({nm, "_xid"}, 64'(io_grant_bits_client_xact_id), 64'(ex));
    sd = io_grant_bits_data;
    sb = {io_grant_bits_g_type, io_grant_bits_addr_beat, io_grant_bits_client_xact_id};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 64'(io_grant_valid), 64'd1);
      chk({nm, "_hold_bits"}, {sd[54:0], sb}, {io_grant_bits_data[54:0], io_grant_bits_g_type,
          io_grant_bits_addr_beat, io_grant_bits_client_xact_id});
      chk({nm, "_hold_acq_ready"}, 64'(io_acquire_ready), 64'd0);
    end
    io_grant_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] t; logic bi; logic [25:0] blk; logic [2:0] beat; logic [7:0] mask; logic [63:0] d; logic [1:0] xid;
    logic [3:0] eg; logic [2:0] eb; logic [63:0] ed; int ecyc; int een;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int e0, g0, w0, op;
    logic [25:0] blk;
    logic [2:0] beat;
    logic [7:0] m;
    logic [63:0] d;
    logic [1:0] x;
    tbl[0] = '{3'd2, 1'b1, 26'h5, 3'd2, 8'hFF, 64'hDEADBEEF_01234567, 2'd1, 4'd1, 3'd0, 64'd0, 2, 1};
    tbl[1] = '{3'd0, 1'b1, 26'h5, 3'd2, 8'h00, 64'd0, 2'd2, 4'd3, 3'd2, 64'hDEADBEEF_01234567, 3, 1};
    tbl[2] = '{3'd2, 1'b1, 26'h0, 3'd0, 8'hFF, 64'd0, 2'd0, 4'd1, 3'd0, 64'd0, 2, 1};
    tbl[3] = '{3'd2, 1'b1, 26'h0, 3'd0, 8'h0F, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 4'd1, 3'd0, 64'd0, 2, 1};
    tbl[4] = '{3'd0, 1'b1, 26'h0, 3'd0, 8'h00, 64'd0, 2'd3, 4'd3, 3'd0, 64'h00000000_FFFFFFFF, 3, 1};
    tbl[5] = '{3'd4, 1'b1, 26'h5, 3'd2, 8'hFF, 64'h1234, 2'd1, 4'd1, 3'd0, 64'd0, 1, 0};
    tbl[6] = '{3'd2, 1'b0, 26'h5, 3'd2, 8'hFF, 64'h5678, 2'd2, 4'd1, 3'd0, 64'd0, 1, 0};
    tbl[7] = '{3'd2, 1'b1, 26'h200, 3'd1, 8'hFF, 64'hA5A5A5A5_5A5A5A5A, 2'd0, 4'd1, 3'd0, 64'd0, 2, 1};
    tbl[8] = '{3'd0, 1'b1, 26'h0, 3'd1, 8'h00, 64'd0, 2'd1, 4'd3, 3'd1, 64'hA5A5A5A5_5A5A5A5A, 3, 1};
    tbl[9] = '{3'd0, 1'b1, 26'h5, 3'd2, 8'h00, 64'd0, 2'd2, 4'd3, 3'd2, 64'hDEADBEEF_01234567, 3, 1};
    for (int i = 0; i < 4096; i++) ref_mem[i] = 64'd0;
    reset_n = 1'b0;
    io_acquire_valid = 1'b0;
    io_grant_ready = 1'b1;
    io_acquire_bits_a_type = '0;
    io_acquire_bits_is_builtin_type = 1'b0;
    io_acquire_bits_addr_block = '0;
    io_acquire_bits_addr_beat = '0;
    io_acquire_bits_union = '0;
    io_acquire_bits_data = '0;
    io_acquire_bits_client_xact_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_acq_ready", 64'(io_acquire_ready), 64'd1);
    chk("rst_grant_valid", 64'(io_grant_valid), 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_sram_we", 64'(sram_we), 64'd0);
    chk("rst_gtype", 64'(io_grant_bits_g_type), 64'd0);
    chk("rst_gdata", io_grant_bits_data, 64'd0);
    chk("rst_builtin", 64'(io_grant_bits_is_builtin_type), 64'd1);
    chk("rst_mgr_id", 64'(io_grant_bits_manager_xact_id), 64'd0);
    chk("rst_sram_addr_mask", 64'({sram_addr, sram_wmask}), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e0 = en_cnt;
      acq(tbl[i].t, tbl[i].bi, tbl[i].blk, tbl[i].beat, tbl[i].mask, tbl[i].d, tbl[i].xid);
      if (tbl[i].t == 3'd2 && tbl[i].bi) ref_mem[widx(tbl[i].blk, tbl[i].beat)] =
          merge(ref_mem[widx(tbl[i].blk, tbl[i].beat)], tbl[i].d, tbl[i].mask);
      grant($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eb, tbl[i].ed, tbl[i].xid, tbl[i].ecyc, 0);
      chk($sformatf("vec%0d_sram_en", i), 64'(en_cnt - e0), 64'(tbl[i].een));
    end

    w0 = wr_log.size();
    g0 = gnt_cnt;
    for (int k = 0; k < 8; k++) begin
      acq(3'd3, 1'b1, 26'h10, 3'(k), 8'hFF, 64'(k) * 64'h1111, 2'd2);
      ref_mem[widx(26'h10, 3'(k))] = 64'(k) * 64'h1111;
    end
    grant("pblk_ack", 4'd1, 3'd0, 64'd0, 2'd2, 2, 0);
    chk("pblk_writes", 64'(wr_log.size() - w0), 64'd8);
    for (int k = 0; k < 8; k++) if (w0 + k < wr_log.size()) chk($sformatf("pblk_idx%0d", k), 64'(wr_log[w0 + k]), 64'(128 + k));
    chk("pblk_grants", 64'(gnt_cnt - g0), 64'd1);

    acq(3'd1, 1'b1, 26'h10, 3'd5, 8'h00, 64'd0, 2'd3);
    for (int k = 0; k < 8; k++)
      grant($sformatf("gblk%0d", k), 4'd4, 3'(k), 64'(k) * 64'h1111, 2'd3, 3, (k == 4) ? 10 : 0);

    g0 = gnt_cnt;
    for (int k = 0; k < 3; k++) begin
      acq(3'd3, 1'b1, 26'h20, 3'(k), 8'hFF, 64'h100 + 64'(k), 2'd1);
      ref_mem[widx(26'h20, 3'(k))] = 64'h100 + 64'(k);
    end
    acq(3'd3, 1'b1, 26'h20, 3'd3, 8'hFF, 64'h103, 2'd1);
    chk("prerst_sram_en", 64'(sram_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_sram_en", 64'(sram_en), 64'd0);
    chk("midrst_grant_valid", 64'(io_grant_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_acq_ready", 64'(io_acquire_ready), 64'd1);
    chk("postrst_no_grant", 64'(gnt_cnt - g0), 64'd0);
    acq(3'd0, 1'b1, 26'h20, 3'd3, 8'h00, 64'd0, 2'd2);
    grant("postrst_get3", 4'd3, 3'd3, ref_mem[widx(26'h20, 3'd3)], 2'd2, 3, 0);
    acq(3'd0, 1'b1, 26'h20, 3'd2, 8'h00, 64'd0, 2'd0);
    grant("postrst_get2", 4'd3, 3'd2, 64'h102, 2'd0, 3, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      blk = 26'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 26'h200 : 26'h0);
      beat = 3'($urandom_range(0, 7));
      x = 2'($urandom_range(0, 3));
      if (op == 0) begin
        acq(3'd0, 1'b1, blk, beat, 8'h00, 64'd0, x);
        grant($sformatf("rnd%0d_get", i), 4'd3, beat, ref_mem[widx(blk, beat)], x, 0, $urandom_range(0, 2));
      end else if (op == 2) begin
        m = 8'($urandom);
        d = {$urandom, $urandom};
        acq(3'd2, 1'b1, blk, beat, m, d, x);
        ref_mem[widx(blk, beat)] = merge(ref_mem[widx(blk, beat)], d, m);
        grant($sformatf("rnd%0d_put", i), 4'd1, 3'd0, 64'd0, x, 2, $urandom_range(0, 2));
      end else if (op == 1) begin
        acq(3'd1, 1'b1, blk, beat, 8'h00, 64'd0, x);
        for (int k = 0; k < 8; k++)
          grant($sformatf("rnd%0d_gblk%0d", i, k), 4'd4, 3'(k), ref_mem[widx(blk, 3'(k))], x, 3, $urandom_range(0, 2));
      end else begin
        for (int k = 0; k < 8; k++) begin
          m = 8'($urandom);
          d = {$urandom, $urandom};
          acq(3'(k == 0 ? 3 : $urandom_range(0, 7)), 1'b1, blk, 3'($urandom_range(0, 7)), m, d, x);
          ref_mem[widx(blk, 3'(k))] = merge(ref_mem[widx(blk, 3'(k))], d, m);
        end
        grant($sformatf("rnd%0d_pblk", i), 4'd1, 3'd0, 64'd0, x, 2, $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
